// File: rtl/seg7_scan_mux_if.sv
// Bus between the scan driver and whatever feeds it the display value.
// The slave side is the driver: it takes the value and drives the decoder and the anodes.
interface seg7_scan_mux_if #(
    parameter int unsigned NDIG = 4
);
    logic [4*NDIG-1:0] data;
    logic [NDIG-1:0]   dp_in;
    logic              load;
    logic              lz_en;
    logic [3:0]        x;
    logic [NDIG-1:0]   an;
    logic              dp;
    logic              frame_tick;

    modport master (
        output data, dp_in, load, lz_en,
        input  x, an, dp, frame_tick
    );

    modport slave (
        input  data, dp_in, load, lz_en,
        output x, an, dp, frame_tick
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment scan driver with a double-buffered value, per-slot anode
// dead-time and optional leading-zero suppression. All outputs are registered.
module seg7_scan_mux #(
    parameter int unsigned NDIG  = 4,
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 500
) (
    input logic            clk,
    input logic            reset,
    seg7_scan_mux_if.slave bus
);
    localparam int unsigned DW = 4 * NDIG;
    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned IW = $clog2(NDIG);

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_t;

    logic [DW-1:0]   pending, active, act_nx;
    logic [NDIG-1:0] pending_dp, active_dp, adp_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic            run;
    logic            wrap, bound, fstart, zrun;
    phase_t          phase;
    logic [3:0]      nib_nx, x_q;
    logic [NDIG-1:0] an_nx, an_q;
    logic            dp_nx, dp_q, tick_q;

    // Next slot position, frame transfer and the output values they imply
    always_comb begin
        wrap   = (cnt == CW'(DIV - 1));
        bound  = !run || wrap;
        cnt_nx = bound ? '0 : cnt + CW'(1);
        idx_nx = idx;
        if (!run) begin
            idx_nx = '0;
        end else if (wrap) begin
            idx_nx = (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
        end
        fstart = bound && (idx_nx == '0);
        act_nx = fstart ? pending : active;
        adp_nx = fstart ? pending_dp : active_dp;
        phase  = (cnt_nx < CW'(BLANK)) ? PH_BLANK : PH_ON;

        nib_nx = '0;
        dp_nx  = 1'b1;
        an_nx  = '1;
        zrun   = 1'b1;
        // Suppression run stops at the first digit (from the top) that is non-zero or has its dp lit
        for (int i = NDIG - 1; i >= 0; i--) begin
            zrun = zrun && (act_nx[4*i +: 4] == 4'h0) && !adp_nx[i];
            if (idx_nx == IW'(i)) begin
                nib_nx = act_nx[4*i +: 4];
                dp_nx  = ~adp_nx[i];
                if (phase == PH_ON && !(bus.lz_en && zrun && i != 0)) begin
                    an_nx[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            pending_dp <= '0;
            active     <= '0;
            active_dp  <= '0;
            cnt        <= '0;
            idx        <= '0;
            run        <= 1'b0;
            x_q        <= '0;
            an_q       <= '1;
            dp_q       <= 1'b1;
            tick_q     <= 1'b0;
        end else begin
            if (bus.load) begin
                pending    <= bus.data;
                pending_dp <= bus.dp_in;
            end
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            run       <= 1'b1;
            active    <= act_nx;
            active_dp <= adp_nx;
            an_q      <= an_nx;
            tick_q    <= fstart;
            if (bound) begin
                x_q  <= nib_nx;
                dp_q <= dp_nx;
            end
        end
    end

    assign bus.x          = x_q;
    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with NDIG=4, DIV=8, BLANK=2: walks whole frames cycle by cycle.
module tb_seg7_scan_mux;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    seg7_scan_mux_if #(.NDIG(4)) bus ();

    seg7_scan_mux #(.NDIG(4), .DIV(8), .BLANK(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of a frame_tick cycle; returns at the next one.
    task automatic frame_chk(input logic [15:0] xs, input logic [3:0] lit, input logic [3:0] dps,
                             input logic e_en, input logic [15:0] e_d, input logic [3:0] e_dp,
                             input logic l_en, input logic [15:0] l_d);
        logic [3:0] sel, e_an, e_x;
        logic       e_dpo, e_tick, one_hot;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                sel     = 4'b0001 << s;
                e_an    = (c < 2 || !lit[s]) ? 4'hF : ~sel;
                e_x     = xs[4*s +: 4];
                e_dpo   = ~dps[s];
                e_tick  = (s == 0 && c == 0);
                one_hot = ($countones(~bus.an) <= 1);
                chk("x", 16'(bus.x), 16'(e_x));
                chk("an", 16'(bus.an), 16'(e_an));
                chk("dp", 16'(bus.dp), 16'(e_dpo));
                chk("frame_tick", 16'(bus.frame_tick), 16'(e_tick));
                chk("an_one_hot", 16'(one_hot), 16'd1);
                bus.load  = 1'b0;
                bus.data  = 16'h0000;
                bus.dp_in = 4'h0;
                if (e_en && s == 0 && c == 0) begin
                    bus.load  = 1'b1;
                    bus.data  = e_d;
                    bus.dp_in = e_dp;
                end
                if (l_en && s == 3 && c == 7) begin
                    bus.load = 1'b1;
                    bus.data = l_d;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        // load held high during reset must be ignored
        bus.load  = 1'b1;
        bus.data  = 16'h1234;
        bus.dp_in = 4'hF;
        bus.lz_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_an", 16'(bus.an), 16'h000F);
        chk("rst_x", 16'(bus.x), 16'h0000);
        chk("rst_dp", 16'(bus.dp), 16'h0001);
        chk("rst_tick", 16'(bus.frame_tick), 16'h0000);
        reset    = 1'b0;
        bus.load = 1'b0;
        @(negedge clk);

        frame_chk(16'h0000, 4'hF, 4'h0, 1'b1, 16'h1234, 4'h0, 1'b0, 16'h0);
        frame_chk(16'h1234, 4'hF, 4'h0, 1'b1, 16'h00A5, 4'h0, 1'b0, 16'h0);
        bus.lz_en = 1'b1;
        frame_chk(16'h00A5, 4'b0011, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0);
        bus.lz_en = 1'b0;
        frame_chk(16'h00A5, 4'hF, 4'h0, 1'b1, 16'h0007, 4'b0100, 1'b0, 16'h0);
        bus.lz_en = 1'b1;
        // 1111 pending, then BEEF loaded on the frame-start edge itself
        frame_chk(16'h0007, 4'b0111, 4'b0100, 1'b1, 16'h1111, 4'h0, 1'b1, 16'hBEEF);
        frame_chk(16'h1111, 4'hF, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0);
        frame_chk(16'hBEEF, 4'hF, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0);

        // Reset during the ON phase of slot 2 (cnt=4)
        repeat (20) @(negedge clk);
        chk("mid_an", 16'(bus.an), 16'h000B);
        chk("mid_x", 16'(bus.x), 16'h000E);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_an", 16'(bus.an), 16'h000F);
        chk("mid_rst_x", 16'(bus.x), 16'h0000);
        chk("mid_rst_dp", 16'(bus.dp), 16'h0001);
        chk("mid_rst_tick", 16'(bus.frame_tick), 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        frame_chk(16'h0000, 4'b0001, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0);
        bus.lz_en = 1'b0;
        frame_chk(16'h0000, 4'hF, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
